// File: rtl/udma_hyper_evt_tracker.sv
// Completion tracker for the uDMA HyperBus wrapper: classifies end-of-transfer
// pulses as read/write, logs {dir, seq} records in a FWFT FIFO, counts and interrupts.
module udma_hyper_evt_tracker #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 sys_clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_evt_i,
  input  logic                 tx_evt_i,
  input  logic                 eot_i,
  input  logic                 clr_i,
  input  logic [1:0]           irq_en_i,
  input  logic                 pop_i,
  output logic                 rec_valid_o,
  output logic                 rec_dir_o,
  output logic [3:0]           rec_seq_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic [CNT_WIDTH-1:0] wr_cnt_o,
  output logic                 evt_rd_o,
  output logic                 evt_wr_o,
  output logic                 irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

  dir_e dir_q, dir_d;
  logic [3:0]                  seq_q;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic [FIFO_DEPTH-1:0]       mem_dir;
  logic [FIFO_DEPTH-1:0][3:0]  mem_seq;
  logic [AW-1:0]               wr_idx, rd_idx;
  logic                        empty, full, do_pop, do_push, drop;
  logic                        is_rd, irq_sel;

  always_comb begin
    dir_d = dir_q;
    if (rx_evt_i && !tx_evt_i)      dir_d = DIR_RD;
    else if (tx_evt_i && !rx_evt_i) dir_d = DIR_WR;
  end

  assign is_rd  = (dir_d == DIR_RD);
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i & ~empty;
  assign do_push = eot_i & (~full | do_pop);
  assign drop    = eot_i & full & ~do_pop;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dir_q      <= DIR_WR;
      seq_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_dir    <= '0;
      mem_seq    <= '0;
      overflow_o <= 1'b0;
      rd_cnt_o   <= '0;
      wr_cnt_o   <= '0;
      evt_rd_o   <= 1'b0;
      evt_wr_o   <= 1'b0;
    end else if (clr_i) begin
      dir_q      <= DIR_WR;
      seq_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_dir    <= '0;
      mem_seq    <= '0;
      overflow_o <= 1'b0;
      rd_cnt_o   <= '0;
      wr_cnt_o   <= '0;
      evt_rd_o   <= 1'b0;
      evt_wr_o   <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      evt_rd_o <= eot_i & is_rd;
      evt_wr_o <= eot_i & ~is_rd;
      if (eot_i) begin
        seq_q <= seq_q + 4'd1;
        if (is_rd) begin
          if (rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          if (wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      if (do_push) begin
        mem_dir[wr_idx] <= is_rd;
        mem_seq[wr_idx] <= seq_q;
        wr_ptr          <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (drop)   overflow_o <= 1'b1;
    end
  end

  assign rec_valid_o = ~empty;
  assign rec_dir_o   = ~empty & mem_dir[rd_idx];
  assign rec_seq_o   = empty ? '0 : mem_seq[rd_idx];

  // Read records are gated by bit0, write records by bit1.
  assign irq_sel = rec_dir_o ? irq_en_i[0] : irq_en_i[1];
  assign irq_o   = (rec_valid_o & irq_sel) | overflow_o;

endmodule

// File: doc/udma_hyper_evt_tracker.md
Name: udma_hyper_evt_tracker

Overview:
Sits directly downstream of the uDMA HyperBus wrapper's event outputs and consumes the RX-channel, TX-channel and HyperBus end-of-transfer pulses. Tracks the direction of the transfer currently in flight and classifies every end-of-transfer as read or write. Logs each completion as a {direction, sequence} record in a small first-word-fall-through FIFO, keeps per-direction completion counters, and drives a level interrupt towards the event unit.

Parameters:
FIFO_DEPTH, 4, number of completion records held; power of two, minimum 2
CNT_WIDTH, 8, width of the per-direction saturating completion counters

Ports:
sys_clk_i  in  1  system clock (the only clock)
rstn_i  in  1  asynchronous active-low reset
rx_evt_i  in  1  RX channel event pulse, 1 cycle
tx_evt_i  in  1  TX channel event pulse, 1 cycle
eot_i  in  1  HyperBus end-of-transaction pulse, 1 cycle
clr_i  in  1  synchronous clear of all state
irq_en_i  in  2  bit0 = read IRQ enable, bit1 = write IRQ enable
pop_i  in  1  consume the head record
rec_valid_o  out  1  head record valid (FIFO not empty)
rec_dir_o  out  1  head record direction, 1 = read, 0 = write
rec_seq_o  out  4  head record sequence number
overflow_o  out  1  sticky flag: a record was dropped
rd_cnt_o  out  CNT_WIDTH  completed reads, saturating
wr_cnt_o  out  CNT_WIDTH  completed writes, saturating
evt_rd_o  out  1  read-completion pulse, registered
evt_wr_o  out  1  write-completion pulse, registered
irq_o  out  1  level interrupt

Behaviour:
- Reset (rstn_i low, asynchronous): every register and every output is 0, including dir_q, seq_q, the FIFO pointers, the counters, overflow_o and the event pulses.
- Direction tracker, combinational next-state dir_d:
  - rx_evt_i & !tx_evt_i gives 1.
  - tx_evt_i & !rx_evt_i gives 0.
  - Both or neither: hold dir_q.
  - dir_q <= dir_d every cycle.
- Classification: an eot_i in cycle N uses dir_d of cycle N, so a same-cycle channel event takes effect.
- Event pulses: evt_rd_o / evt_wr_o = registered (eot_i & dir_d) / (eot_i & !dir_d). Each is high for exactly cycle N+1.
- Counters: on eot_i, rd_cnt_o or wr_cnt_o increments at cycle N+1. Each counter saturates at all-ones and never wraps.
- Sequence: seq_q increments on every eot_i, including a dropped one, and wraps 15 to 0. A pushed record carries the pre-increment value of seq_q.
- FIFO:
  - Push on eot_i; the record is visible on the rec_* outputs from cycle N+1.
  - Pop on pop_i & rec_valid_o. The next head, or rec_valid_o = 0, is visible the following cycle.
  - pop_i while empty is ignored.
  - Push and pop in the same cycle: both occur, including when full, so a simultaneous pop makes room.
  - Full with push and no pop: the record is dropped and overflow_o is set at N+1. overflow_o stays set until clr_i or reset. Counters and pulses still update.
  - rec_dir_o / rec_seq_o are 0 when empty.
- irq_o (combinational) = (rec_valid_o & irq_en_i[rec_dir_o ? 0 : 1]) | overflow_o.
- clr_i: next cycle, all state returns to reset values. clr_i has priority over a same-cycle eot_i, pop_i and channel events; those are discarded and no event pulse is produced.
- Reset mid-operation: takes effect immediately, with no partial record retained.

Test Plan:
- rx_evt_i pulse, 3 cycles later eot_i -> evt_rd_o=1 for exactly 1 cycle; rd_cnt_o=1; head record dir=1, seq=0; irq_o=1 only when irq_en_i=2'b01.
- rx_evt_i and eot_i in the same cycle with dir_q=0 -> classified as read; tx_evt_i and rx_evt_i together -> direction held.
- 5 eot_i pulses with no pops, FIFO_DEPTH=4 -> 4 records with seq 0..3; overflow_o=1; irq_o=1 with irq_en_i=0. One pop plus one eot_i on the full FIFO in the same cycle -> next record seq=5, FIFO stays full.
- 300 write completions with CNT_WIDTH=8 -> wr_cnt_o=255; seq wraps, with record seq values following 15,0,1 across the wrap.
- clr_i in the same cycle as eot_i -> no pulse, counters 0, FIFO empty, overflow_o=0, seq restarts at 0.
- rstn_i low asynchronously with the FIFO holding 2 records -> all outputs 0 immediately; pop_i while empty has no effect.
